dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL be clocked by a single clock, clk, on its rising edge; reset rst SHALL be asynchronous and active-high.
REQ-002 Parameter AW, default 32, SHALL set the requester address width.
REQ-003 Parameter DW, default 32, SHALL set the data width; only 32 is supported.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 a_req_valid / b_req_valid  input  1  requester A/B has a request.
REQ-007 a_req_ready / b_req_ready  output  1  request accepted this cycle.
REQ-008 a_req_addr / b_req_addr  input  AW  byte address.
REQ-009 a_req_rop / b_req_rop  input  3  read op: 000 none, 001 LW, 010 LH, 011 LHU, 100 LB, 101 LBU.
REQ-010 a_req_wop / b_req_wop  input  2  write op: 00 none, 01 SW, 10 SH, 11 SB.
REQ-011 a_req_wdata / b_req_wdata  input  DW  store data.
REQ-012 a_rsp_valid / b_rsp_valid  output  1  response pending for A/B.
REQ-013 a_rsp_ready / b_rsp_ready  input  1  requester consumes the response.
REQ-014 rsp_data  output  DW  shared response data; valid only with x_rsp_valid.
REQ-015 rsp_err  output  1  shared error flag; valid only with x_rsp_valid.
REQ-016 mem_read  output  3  read-op code to the data memory.
REQ-017 mem_write  output  2  write-op code to the data memory.
REQ-018 mem_addr  output  32  address to the data memory.
REQ-019 mem_wdata  output  DW  store data to the data memory.
REQ-020 mem_rdata  input  DW  combinational read data from the data memory.

Function
REQ-021 The block SHALL contain a single-entry response buffer: rsp_pend, rsp_owner (A/B), rsp_data, rsp_err.
REQ-022 Accept is possible (can_acc) when !rsp_pend, or when the pending response is consumed this cycle (x_rsp_valid & x_rsp_ready for the owner).
REQ-023 Arbitration SHALL be round-robin, using register last_grant: with both requesters valid, the one not in last_grant wins; with one requester valid, it wins.
REQ-024 x_req_ready = can_acc & grant_x, combinational; at most one ready SHALL be high per cycle.
REQ-025 In an accept cycle, mem_read, mem_write, mem_addr and mem_wdata SHALL carry the winner's rop, wop, addr (zero-extended or truncated to 32 bits) and wdata; otherwise mem_read=000, mem_write=00, mem_addr=0, mem_wdata=0.
REQ-026 If both rop!=000 and wop!=00: mem_read=000 is driven, the write proceeds, and rsp_err=1.
REQ-027 rop values 110 and 111 SHALL be driven as mem_read=000 with rsp_err=1.
REQ-028 Misalignment SHALL set rsp_err=1 without suppressing the access: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]=1.
REQ-029 At the accept edge: rsp_pend<=1; rsp_owner<=winner; last_grant<=winner; rsp_data<=mem_rdata for a read, or 0 for a write or no-op.
REQ-030 A consume without a same-cycle accept SHALL clear rsp_pend at the edge; consume plus accept SHALL reload the buffer (back-to-back, one transaction per cycle).
REQ-031 x_rsp_valid = rsp_pend & (rsp_owner==x); responses SHALL return in acceptance order with latency exactly 1 cycle when x_rsp_ready is held high.
REQ-032 A no-op request (rop=000, wop=00) SHALL be accepted and SHALL return rsp_data=0, rsp_err=0.
REQ-033 x_rsp_ready while x_rsp_valid=0 SHALL be ignored.
REQ-034 Request inputs SHALL be sampled only in an accept cycle; no request is buffered internally.

Reset
REQ-035 While rst=1, asynchronously: rsp_pend=0, rsp_owner=A, last_grant=B, rsp_data=0, rsp_err=0; all ready/valid outputs are 0 and the mem_* ops are 0.
REQ-036 With reset asserted mid-transaction, any pending response SHALL be discarded and no memory write SHALL be issued in that cycle.
REQ-037 After reset release, A SHALL win the first contested arbitration.

Verification
REQ-038 A LW addr 0x04 with memory word 0x00010106, A rsp_ready=1 -> a_req_ready same cycle, a_rsp_valid next cycle, rsp_data=0x00010106, rsp_err=0.
REQ-039 A and B valid every cycle with rsp_ready=1 -> grants alternate A,B,A,B starting with A; one response per cycle.
REQ-040 B SB 0x000000AB to addr 0x08, then B LBU addr 0x08 -> rsp_data=0x000000AB; write response rsp_data=0.
REQ-041 A LH addr 0x05 -> rsp_err=1; A LW with wop=01 -> write performed, mem_read=000, rsp_err=1.
REQ-042 a_rsp_ready=0 for 3 cycles while B is valid -> b_req_ready=0 throughout, a_rsp_valid and rsp_data held; b_req_ready=1 in the cycle a_rsp_ready rises.
REQ-043 rst pulsed while a response is pending -> a_rsp_valid=0 immediately, and A wins the next contested grant.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester A/B, shared response and data-memory signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          a_req_valid;
  logic          a_req_ready;
  logic [AW-1:0] a_req_addr;
  logic [2:0]    a_req_rop;
  logic [1:0]    a_req_wop;
  logic [DW-1:0] a_req_wdata;
  logic          a_rsp_valid;
  logic          a_rsp_ready;

  logic          b_req_valid;
  logic          b_req_ready;
  logic [AW-1:0] b_req_addr;
  logic [2:0]    b_req_rop;
  logic [1:0]    b_req_wop;
  logic [DW-1:0] b_req_wdata;
  logic          b_rsp_valid;
  logic          b_rsp_ready;

  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  logic [2:0]    mem_read;
  logic [1:0]    mem_write;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  a_req_valid, a_req_addr, a_req_rop, a_req_wop, a_req_wdata, a_rsp_ready,
    input  b_req_valid, b_req_addr, b_req_rop, b_req_wop, b_req_wdata, b_rsp_ready,
    input  mem_rdata,
    output a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid,
    output rsp_data, rsp_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output a_req_valid, a_req_addr, a_req_rop, a_req_wop, a_req_wdata, a_rsp_ready,
    output b_req_valid, b_req_addr, b_req_rop, b_req_wop, b_req_wdata, b_rsp_ready,
    output mem_rdata,
    input  a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid,
    input  rsp_data, rsp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-requester data-memory arbiter with a single-entry response buffer
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam logic [2:0] ROP_NONE = 3'b000;
  localparam logic [2:0] ROP_LW   = 3'b001;
  localparam logic [2:0] ROP_LH   = 3'b010;
  localparam logic [2:0] ROP_LHU  = 3'b011;
  localparam logic [1:0] WOP_NONE = 2'b00;
  localparam logic [1:0] WOP_SW   = 2'b01;
  localparam logic [1:0] WOP_SH   = 2'b10;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_t;

  sel_t          rsp_owner;
  sel_t          last_grant;
  sel_t          winner;
  logic          rsp_pend;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_err_q;

  logic          consume;
  logic          can_acc;
  logic          grant_a;
  logic          grant_b;
  logic          accept;

  logic [2:0]    w_rop;
  logic [1:0]    w_wop;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  logic          bad_rop;
  logic          op_clash;
  logic          misalign;
  logic [2:0]    eff_rop;
  logic          req_err;

  // Requests are gated off during reset so nothing reaches memory while rst is high.
  always_comb begin
    consume = rsp_pend & ((rsp_owner == SEL_A) ? bus.a_rsp_ready : bus.b_rsp_ready);
    can_acc = !rst & (!rsp_pend | consume);
    grant_a = bus.a_req_valid & (!bus.b_req_valid | (last_grant == SEL_B));
    grant_b = bus.b_req_valid & (!bus.a_req_valid | (last_grant == SEL_A));
    accept  = can_acc & (grant_a | grant_b);
    winner  = grant_b ? SEL_B : SEL_A;
  end

  always_comb begin
    w_rop   = ROP_NONE;
    w_wop   = WOP_NONE;
    w_addr  = '0;
    w_wdata = '0;
    if (winner == SEL_B) begin
      w_rop   = bus.b_req_rop;
      w_wop   = bus.b_req_wop;
      w_addr  = bus.b_req_addr;
      w_wdata = bus.b_req_wdata;
    end else begin
      w_rop   = bus.a_req_rop;
      w_wop   = bus.a_req_wop;
      w_addr  = bus.a_req_addr;
      w_wdata = bus.a_req_wdata;
    end
  end

  // Misalignment only flags the response; the access still goes out unchanged.
  always_comb begin
    bad_rop  = (w_rop[2:1] == 2'b11);
    op_clash = (w_rop != ROP_NONE) && (w_wop != WOP_NONE);
    misalign = 1'b0;
    case (w_rop)
      ROP_LW:          misalign = (w_addr[1:0] != 2'b00);
      ROP_LH, ROP_LHU: misalign = w_addr[0];
      default:         misalign = 1'b0;
    endcase
    case (w_wop)
      WOP_SW:  misalign = misalign | (w_addr[1:0] != 2'b00);
      WOP_SH:  misalign = misalign | w_addr[0];
      default: misalign = misalign;
    endcase
    eff_rop = (bad_rop | op_clash) ? ROP_NONE : w_rop;
    req_err = bad_rop | op_clash | misalign;
  end

  assign bus.a_req_ready = can_acc & grant_a;
  assign bus.b_req_ready = can_acc & grant_b;
  assign bus.a_rsp_valid = rsp_pend & (rsp_owner == SEL_A);
  assign bus.b_rsp_valid = rsp_pend & (rsp_owner == SEL_B);
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;

  assign bus.mem_read    = accept ? eff_rop : ROP_NONE;
  assign bus.mem_write   = accept ? w_wop : WOP_NONE;
  assign bus.mem_addr    = accept ? 32'(w_addr) : 32'h0;
  assign bus.mem_wdata   = accept ? w_wdata : '0;

  // Consume and accept in the same cycle simply reloads the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_pend   <= 1'b0;
      rsp_owner  <= SEL_A;
      last_grant <= SEL_B;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (accept) begin
      rsp_pend   <= 1'b1;
      rsp_owner  <= winner;
      last_grant <= winner;
      rsp_data_q <= (eff_rop != ROP_NONE) ? bus.mem_rdata : '0;
      rsp_err_q  <= req_err;
    end else if (consume) begin
      rsp_pend   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vectors, corner sequences and random traffic against a queue-based model
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();
  dmem_arbiter #(.AW(32), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        av;   logic [2:0] arop; logic [1:0] awop; logic [31:0] aaddr; logic [31:0] awd; logic ardy;
    logic        bv;   logic [2:0] brop; logic [1:0] bwop; logic [31:0] baddr; logic [31:0] bwd; logic brdy;
    logic        e_ar; logic       e_br; logic [2:0] e_mr; logic [1:0]  e_mw;
    logic        e_av; logic       e_bv; logic [31:0] e_data; logic     e_err;
  } vec_t;

  typedef struct {
    int          owner;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] mem_load(input logic [31:0] w, input logic [1:0] off, input logic [2:0] rop);
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? w[31:16] : w[15:0];
    b = 8'(w >> (8 * off));
    case (rop)
      3'd1:    return w;
      3'd2:    return {{16{h[15]}}, h};
      3'd3:    return {16'h0, h};
      3'd4:    return {{24{b[7]}}, b};
      3'd5:    return {24'h0, b};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mem_merge(input logic [31:0] w, input logic [1:0] off, input logic [1:0] wop, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (wop)
      2'd1: r = d;
      2'd2: if (off[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      2'd3: r[8 * off +: 8] = d[7:0];
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic int bytes_r(input logic [2:0] rop);
    if (rop == 3'd1) return 4;
    if (rop == 3'd2 || rop == 3'd3) return 2;
    return 1;
  endfunction

  function automatic int bytes_w(input logic [1:0] wop);
    if (wop == 2'd1) return 4;
    if (wop == 2'd2) return 2;
    return 1;
  endfunction

  always_comb bus.mem_rdata = mem_load(mem[bus.mem_addr[7:2]], bus.mem_addr[1:0], bus.mem_read);

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mem_init();
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'(i) * 32'h01030507 + 32'h00C0FFEE;
      ref_mem[i] = 32'(i) * 32'h01030507 + 32'h00C0FFEE;
    end
    mem[1] = 32'h00010106; ref_mem[1] = 32'h00010106;
    mem[2] = 32'h0;        ref_mem[2] = 32'h0;
  endtask

  task automatic set_in(input vec_t v);
    bus.a_req_valid = v.av;  bus.a_req_rop = v.arop; bus.a_req_wop = v.awop;
    bus.a_req_addr  = v.aaddr; bus.a_req_wdata = v.awd; bus.a_rsp_ready = v.ardy;
    bus.b_req_valid = v.bv;  bus.b_req_rop = v.brop; bus.b_req_wop = v.bwop;
    bus.b_req_addr  = v.baddr; bus.b_req_wdata = v.bwd; bus.b_rsp_ready = v.brdy;
  endtask

  // The environment memory commits a store just after the edge that accepted it.
  task automatic step();
    logic [1:0]  wop;
    logic [31:0] wa;
    logic [31:0] wd;
    wop = bus.mem_write; wa = bus.mem_addr; wd = bus.mem_wdata;
    @(posedge clk);
    #1;
    if (wop != 2'b00) mem[wa[7:2]] = mem_merge(mem[wa[7:2]], wa[1:0], wop, wd);
  endtask

  task automatic do_reset();
    vec_t z;
    z = '{default: '0};
    set_in(z);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    vec_t tbl [15];
    vec_t v;
    vec_t z;
    rsp_t rq [$];
    rsp_t nr;
    int lg, win;
    logic consumed, free_slot, e_av, e_bv, mis, bad, clash;
    logic [2:0]  r_rop, e_mr;
    logic [1:0]  r_wop;
    logic [31:0] r_addr, r_wd;

    z = '{default: '0};
    mem_init();
    rst = 1'b1;
    v = z; v.av = 1; v.arop = 3'd1; v.bv = 1; v.bwop = 2'd1; v.ardy = 1; v.brdy = 1;
    set_in(v);
    #1;
    check1("rst_a_ready", bus.a_req_ready, 1'b0);
    check1("rst_b_ready", bus.b_req_ready, 1'b0);
    check1("rst_a_rsp_valid", bus.a_rsp_valid, 1'b0);
    check1("rst_b_rsp_valid", bus.b_rsp_valid, 1'b0);
    check32("rst_mem_read", 32'(bus.mem_read), 32'h0);
    check32("rst_mem_write", 32'(bus.mem_write), 32'h0);
    check32("rst_rsp_data", bus.rsp_data, 32'h0);
    check1("rst_rsp_err", bus.rsp_err, 1'b0);
    do_reset();

    //         av arop awop aaddr  awd            ardy bv brop bwop baddr  bwd            brdy ar br mr mw av bv data            err
    tbl[0]  = '{1, 1,  0,   32'h04, 32'h0,         1,   0, 0,  0,   32'h0,  32'h0,         1,   1, 0, 1, 0, 0, 0, 32'h0,          0};
    tbl[1]  = '{0, 0,  0,   32'h0,  32'h0,         1,   0, 0,  0,   32'h0,  32'h0,         1,   0, 0, 0, 0, 1, 0, 32'h00010106,   0};
    tbl[2]  = '{0, 0,  0,   32'h0,  32'h0,         1,   1, 0,  3,   32'h08, 32'h123456AB,  1,   0, 1, 0, 3, 0, 0, 32'h0,          0};
    tbl[3]  = '{0, 0,  0,   32'h0,  32'h0,         1,   1, 5,  0,   32'h08, 32'h0,         1,   0, 1, 5, 0, 0, 1, 32'h0,          0};
    tbl[4]  = '{0, 0,  0,   32'h0,  32'h0,         1,   0, 0,  0,   32'h0,  32'h0,         1,   0, 0, 0, 0, 0, 1, 32'hAB,         0};
    tbl[5]  = '{1, 2,  0,   32'h05, 32'h0,         1,   0, 0,  0,   32'h0,  32'h0,         1,   1, 0, 2, 0, 0, 0, 32'h0,          0};
    tbl[6]  = '{1, 1,  1,   32'h0C, 32'hDEADBEEF,  1,   0, 0,  0,   32'h0,  32'h0,         1,   1, 0, 0, 1, 1, 0, 32'h00000106,   1};
    tbl[7]  = '{1, 1,  0,   32'h0C, 32'h0,         1,   0, 0,  0,   32'h0,  32'h0,         1,   1, 0, 1, 0, 1, 0, 32'h0,          1};
    tbl[8]  = '{0, 0,  0,   32'h0,  32'h0,         1,   0, 0,  0,   32'h0,  32'h0,         1,   0, 0, 0, 0, 1, 0, 32'hDEADBEEF,   0};
    tbl[9]  = '{1, 6,  0,   32'h0,  32'h0,         1,   0, 0,  0,   32'h0,  32'h0,         1,   1, 0, 0, 0, 0, 0, 32'h0,          0};
    tbl[10] = '{0, 0,  0,   32'h0,  32'h0,         1,   0, 0,  0,   32'h0,  32'h0,         1,   0, 0, 0, 0, 1, 0, 32'h0,          1};
    tbl[11] = '{1, 0,  0,   32'h20, 32'h0,         1,   0, 0,  0,   32'h0,  32'h0,         1,   1, 0, 0, 0, 0, 0, 32'h0,          0};
    tbl[12] = '{0, 0,  0,   32'h0,  32'h0,         1,   0, 0,  0,   32'h0,  32'h0,         1,   0, 0, 0, 0, 1, 0, 32'h0,          0};
    tbl[13] = '{0, 0,  0,   32'h0,  32'h0,         1,   1, 0,  1,   32'h12, 32'h11112222,  1,   0, 1, 0, 1, 0, 0, 32'h0,          0};
    tbl[14] = '{0, 0,  0,   32'h0,  32'h0,         1,   0, 0,  0,   32'h0,  32'h0,         1,   0, 0, 0, 0, 0, 1, 32'h0,          1};

    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i]);
      #1;
      check1($sformatf("v%0d_a_ready", i), bus.a_req_ready, tbl[i].e_ar);
      check1($sformatf("v%0d_b_ready", i), bus.b_req_ready, tbl[i].e_br);
      check32($sformatf("v%0d_mem_read", i), 32'(bus.mem_read), 32'(tbl[i].e_mr));
      check32($sformatf("v%0d_mem_write", i), 32'(bus.mem_write), 32'(tbl[i].e_mw));
      check1($sformatf("v%0d_a_rsp_valid", i), bus.a_rsp_valid, tbl[i].e_av);
      check1($sformatf("v%0d_b_rsp_valid", i), bus.b_rsp_valid, tbl[i].e_bv);
      if (tbl[i].e_av | tbl[i].e_bv) begin
        check32($sformatf("v%0d_rsp_data", i), bus.rsp_data, tbl[i].e_data);
        check1($sformatf("v%0d_rsp_err", i), bus.rsp_err, tbl[i].e_err);
      end
      step();
    end

    // Contested traffic after reset alternates A,B,A,B with one response per cycle.
    mem_init();
    do_reset();
    v = z; v.av = 1; v.arop = 3'd1; v.aaddr = 32'h04; v.bv = 1; v.brop = 3'd1; v.baddr = 32'h08;
    v.ardy = 1; v.brdy = 1;
    set_in(v);
    for (int i = 0; i < 6; i++) begin
      #1;
      check1($sformatf("alt%0d_a_ready", i), bus.a_req_ready, (i % 2) == 0);
      check1($sformatf("alt%0d_b_ready", i), bus.b_req_ready, (i % 2) == 1);
      if (i > 0) begin
        check1($sformatf("alt%0d_a_rsp_valid", i), bus.a_rsp_valid, (i % 2) == 1);
        check1($sformatf("alt%0d_b_rsp_valid", i), bus.b_rsp_valid, (i % 2) == 0);
        check32($sformatf("alt%0d_rsp_data", i), bus.rsp_data, ((i % 2) == 1) ? 32'h00010106 : 32'h0);
      end
      step();
    end

    // Stalled A response blocks B until a_rsp_ready rises.
    set_in(z); step();
    v = z; v.av = 1; v.arop = 3'd1; v.aaddr = 32'h04; v.ardy = 1; v.brdy = 1;
    set_in(v); #1;
    check1("stall_a_accept", bus.a_req_ready, 1'b1);
    step();
    v = z; v.bv = 1; v.brop = 3'd1; v.baddr = 32'h08; v.ardy = 0; v.brdy = 1;
    set_in(v);
    for (int k = 0; k < 3; k++) begin
      #1;
      check1($sformatf("stall%0d_b_ready", k), bus.b_req_ready, 1'b0);
      check1($sformatf("stall%0d_a_rsp_valid", k), bus.a_rsp_valid, 1'b1);
      check32($sformatf("stall%0d_rsp_data", k), bus.rsp_data, 32'h00010106);
      step();
    end
    v.ardy = 1;
    set_in(v); #1;
    check1("stall_release_b_ready", bus.b_req_ready, 1'b1);
    step();

    // Reset while A's response is pending: response dropped, no store, A wins next.
    v = z; v.av = 1; v.arop = 3'd1; v.aaddr = 32'h04; v.ardy = 0; v.brdy = 1;
    set_in(v); #1;
    check1("rmid_a_accept", bus.a_req_ready, 1'b1);
    step();
    v = z; v.bv = 1; v.bwop = 2'd1; v.baddr = 32'h10; v.bwd = 32'hCAFEF00D; v.ardy = 0; v.brdy = 1;
    set_in(v); #1;
    check1("rmid_pend_before", bus.a_rsp_valid, 1'b1);
    rst = 1'b1;
    #1;
    check1("rmid_a_rsp_valid", bus.a_rsp_valid, 1'b0);
    check1("rmid_b_ready", bus.b_req_ready, 1'b0);
    check32("rmid_mem_write", 32'(bus.mem_write), 32'h0);
    step();
    rst = 1'b0;
    v = z; v.av = 1; v.arop = 3'd1; v.aaddr = 32'h04; v.bv = 1; v.bwop = 2'd1; v.baddr = 32'h10;
    v.ardy = 1; v.brdy = 1;
    set_in(v); #1;
    check1("rmid_next_a_ready", bus.a_req_ready, 1'b1);
    check1("rmid_next_b_ready", bus.b_req_ready, 1'b0);
    check32("rmid_next_mem_read", 32'(bus.mem_read), 32'h1);
    step();

    // Random traffic against the queue model.
    mem_init();
    do_reset();
    rq.delete();
    lg = 1;
    for (int c = 0; c < 600; c++) begin
      v = z;
      v.av = ($urandom_range(0, 9) < 6);
      v.arop = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      v.awop = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      v.aaddr = $urandom(); v.awd = $urandom(); v.ardy = ($urandom_range(0, 9) < 7);
      v.bv = ($urandom_range(0, 9) < 6);
      v.brop = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      v.bwop = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      v.baddr = $urandom(); v.bwd = $urandom(); v.brdy = ($urandom_range(0, 9) < 7);
      set_in(v);
      #1;

      e_av = (rq.size() > 0) && (rq[0].owner == 0);
      e_bv = (rq.size() > 0) && (rq[0].owner == 1);
      consumed  = (rq.size() > 0) && ((rq[0].owner == 0) ? v.ardy : v.brdy);
      free_slot = (rq.size() == 0) || consumed;
      win = -1;
      if (v.av && v.bv) win = (lg == 0) ? 1 : 0;
      else if (v.av)    win = 0;
      else if (v.bv)    win = 1;
      if (!free_slot) win = -1;

      r_rop = 3'd0; r_wop = 2'd0; r_addr = 32'h0; r_wd = 32'h0;
      if (win == 0) begin r_rop = v.arop; r_wop = v.awop; r_addr = v.aaddr; r_wd = v.awd; end
      if (win == 1) begin r_rop = v.brop; r_wop = v.bwop; r_addr = v.baddr; r_wd = v.bwd; end
      bad   = (r_rop > 3'd5);
      clash = (r_rop != 3'd0) && (r_wop != 2'd0);
      mis   = ((r_addr % bytes_r(r_rop)) != 0) || ((r_addr % bytes_w(r_wop)) != 0);
      e_mr  = (bad || clash) ? 3'd0 : r_rop;

      check1($sformatf("rnd%0d_a_ready", c), bus.a_req_ready, win == 0);
      check1($sformatf("rnd%0d_b_ready", c), bus.b_req_ready, win == 1);
      check32($sformatf("rnd%0d_mem_read", c), 32'(bus.mem_read), 32'(e_mr));
      check32($sformatf("rnd%0d_mem_write", c), 32'(bus.mem_write), 32'(r_wop));
      check32($sformatf("rnd%0d_mem_addr", c), bus.mem_addr, r_addr);
      check32($sformatf("rnd%0d_mem_wdata", c), bus.mem_wdata, r_wd);
      check1($sformatf("rnd%0d_a_rsp_valid", c), bus.a_rsp_valid, e_av);
      check1($sformatf("rnd%0d_b_rsp_valid", c), bus.b_rsp_valid, e_bv);
      if (rq.size() > 0) begin
        check32($sformatf("rnd%0d_rsp_data", c), bus.rsp_data, rq[0].data);
        check1($sformatf("rnd%0d_rsp_err", c), bus.rsp_err, rq[0].err);
      end

      step();

      if (consumed) void'(rq.pop_front());
      if (win >= 0) begin
        nr.owner = win;
        nr.data  = (e_mr != 3'd0) ? mem_load(ref_mem[r_addr[7:2]], r_addr[1:0], e_mr) : 32'h0;
        nr.err   = bad || clash || mis;
        rq.push_back(nr);
        if (r_wop != 2'd0) ref_mem[r_addr[7:2]] = mem_merge(ref_mem[r_addr[7:2]], r_addr[1:0], r_wop, r_wd);
        lg = win;
      end
    end

    set_in(z);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
